// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registered RV32I branch compare and mispredict check.
// Trains a direct-mapped 2-bit counter table and keeps branch/mispredict perf counters.
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             req_valid,
    input  logic [2:0]       cmpop,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [WIDTH-1:0] pc,
    input  logic             pred_taken,
    output logic             res_valid,
    output logic             br_en,
    output logic             mispredict,
    input  logic [WIDTH-1:0] lookup_pc,
    output logic             lookup_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;

    logic [1:0]       bht [BHT_DEPTH];
    logic             outcome;
    logic             legal;
    logic             accept;
    logic             mis_now;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lkp_idx;
    logic [1:0]       cur_ctr;
    logic [1:0]       nxt_ctr;
    logic             unused_bits;

    assign accept  = req_valid & ~stall & ~flush;
    assign upd_idx = pc[IDX_W+1:2];
    assign lkp_idx = lookup_pc[IDX_W+1:2];
    assign mis_now = outcome ^ pred_taken;
    assign cur_ctr = bht[upd_idx];

    // Read-old lookup: reflects table contents before this cycle's update.
    assign lookup_taken = bht[lkp_idx][1];

    // Only the index bits of the PCs are used; fold the rest away.
    assign unused_bits = ^{pc, lookup_pc};

    // Decode funct3 and evaluate the comparison; reserved encodings never branch.
    always_comb begin
        outcome = 1'b0;
        legal   = 1'b1;
        unique case (cmpop)
            F3_BEQ:  outcome = (rs1 == rs2);
            F3_BNE:  outcome = (rs1 != rs2);
            F3_BLT:  outcome = ($signed(rs1) < $signed(rs2));
            F3_BGE:  outcome = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: outcome = (rs1 < rs2);
            F3_BGEU: outcome = (rs1 >= rs2);
            default: legal = 1'b0;
        endcase
    end

    // Saturating step of the indexed counter toward the resolved direction.
    always_comb begin
        nxt_ctr = cur_ctr;
        if (outcome) begin
            if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
        end
    end

    // Result registers and perf counters; flush wins over stall, reset over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid     <= 1'b0;
            br_en         <= 1'b0;
            mispredict    <= 1'b0;
            branch_count  <= '0;
            mispred_count <= '0;
        end else if (flush) begin
            res_valid  <= 1'b0;
            br_en      <= 1'b0;
            mispredict <= 1'b0;
        end else if (!stall) begin
            if (req_valid) begin
                res_valid     <= 1'b1;
                br_en         <= outcome;
                mispredict    <= mis_now;
                branch_count  <= branch_count + CNT_W'(1);
                mispred_count <= mispred_count + CNT_W'(mis_now);
            end else begin
                res_valid  <= 1'b0;
                br_en      <= 1'b0;
                mispredict <= 1'b0;
            end
        end
    end

    // Branch history table: single-cycle read-modify-write on accepted legal branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && legal) begin
            bht[upd_idx] <= nxt_ctr;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vectors with a scoreboard queue
// and a negedge monitor that checks each result one cycle after acceptance.
module tb_branch_resolve_unit;

    bit          clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        req_valid;
    logic [2:0]  cmpop;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic        pred_taken;
    logic        res_valid;
    logic        br_en;
    logic        mispredict;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [3:0]  branch_count;
    logic [3:0]  mispred_count;

    typedef struct packed {
        logic       br;
        logic       mis;
        logic [3:0] bc;
        logic [3:0] mc;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_bc = '0;
    logic [3:0] m_mc = '0;
    int         errors = 0;
    int         checks = 0;
    logic       acc_q = 1'b0;
    logic       hold_q = 1'b0;

    branch_resolve_unit #(
        .WIDTH(32),
        .BHT_DEPTH(64),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .req_valid(req_valid),
        .cmpop(cmpop),
        .rs1(rs1),
        .rs2(rs2),
        .pc(pc),
        .pred_taken(pred_taken),
        .res_valid(res_valid),
        .br_en(br_en),
        .mispredict(mispredict),
        .lookup_pc(lookup_pc),
        .lookup_taken(lookup_taken),
        .branch_count(branch_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Apply one request; if it will be accepted, push its hand-computed response.
    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p,
                         input logic pt, input logic br);
        exp_t e;
        req_valid  = v;
        cmpop      = op;
        rs1        = a;
        rs2        = b;
        pc         = p;
        pred_taken = pt;
        if (v && !stall && !flush && !rst) begin
            m_bc = m_bc + 4'd1;
            if (br != pt) m_mc = m_mc + 4'd1;
            e.br  = br;
            e.mis = (br != pt);
            e.bc  = m_bc;
            e.mc  = m_mc;
            q.push_back(e);
        end
    endtask

    task automatic idle;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        idle();
        tick();
        rst  = 1'b0;
        m_bc = '0;
        m_mc = '0;
    endtask

    // Remember what the last edge was supposed to do.
    always @(posedge clk) begin
        acc_q  <= req_valid && !stall && !flush && !rst;
        hold_q <= stall && !flush && !rst;
    end

    // Monitor: pop and compare whenever a fresh result is presented.
    always @(negedge clk) begin
        exp_t e;
        if (acc_q) begin
            if (res_valid !== 1'b1) begin
                chk("mon_res_valid", {31'b0, res_valid}, 32'h1);
            end else if (q.size() == 0) begin
                chk("mon_queue_empty", 32'h0, 32'h1);
            end else begin
                e = q.pop_front();
                chk("mon_br_en", {31'b0, br_en}, {31'b0, e.br});
                chk("mon_mispredict", {31'b0, mispredict}, {31'b0, e.mis});
                chk("mon_branch_count", {28'b0, branch_count}, {28'b0, e.bc});
                chk("mon_mispred_count", {28'b0, mispred_count}, {28'b0, e.mc});
            end
        end else if (!hold_q) begin
            chk("mon_idle_res_valid", {31'b0, res_valid}, 32'h0);
        end
    end

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        lookup_pc = '0;
        idle();
        tick();
        tick();
        chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_br_en", {31'b0, br_en}, 32'h0);
        chk("rst_mispredict", {31'b0, mispredict}, 32'h0);
        chk("rst_branch_count", {28'b0, branch_count}, 32'h0);
        chk("rst_mispred_count", {28'b0, mispred_count}, 32'h0);
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i) << 2;
            #1;
            chk("rst_lookup", {31'b0, lookup_taken}, 32'h0);
        end
        rst = 1'b0;

        // compare sweep, pred_taken=0, pc idx 0
        drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1); tick();
        drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'b101, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'b111, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b1); tick();
        drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h0, 1'b0, 1'b1); tick();
        drive(1'b1, 3'b001, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'b010, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0); tick();
        idle(); tick();

        // training at pc 0x40 (idx 16)
        lookup_pc = 32'h40;
        #1;
        chk("train_init", {31'b0, lookup_taken}, 32'h0);
        drive(1'b1, 3'b000, 32'h1, 32'h1, 32'h40, 1'b1, 1'b1); tick();
        chk("train_t1", {31'b0, lookup_taken}, 32'h1);
        drive(1'b1, 3'b000, 32'h1, 32'h1, 32'h40, 1'b1, 1'b1); tick();
        chk("train_t2", {31'b0, lookup_taken}, 32'h1);
        drive(1'b1, 3'b000, 32'h1, 32'h1, 32'h40, 1'b1, 1'b1); tick();
        chk("train_t3", {31'b0, lookup_taken}, 32'h1);
        drive(1'b1, 3'b000, 32'h1, 32'h2, 32'h40, 1'b0, 1'b0); tick();
        chk("train_n1", {31'b0, lookup_taken}, 32'h1);
        drive(1'b1, 3'b000, 32'h1, 32'h2, 32'h40, 1'b0, 1'b0); tick();
        chk("train_n2", {31'b0, lookup_taken}, 32'h0);
        drive(1'b1, 3'b000, 32'h1, 32'h2, 32'h40, 1'b0, 1'b0); tick();
        chk("train_n3", {31'b0, lookup_taken}, 32'h0);
        drive(1'b1, 3'b000, 32'h1, 32'h1, 32'h40, 1'b0, 1'b1); tick();
        chk("train_sat_low", {31'b0, lookup_taken}, 32'h0);
        idle(); tick();

        // mispredict accounting from a fresh reset
        pulse_reset();
        drive(1'b1, 3'b000, 32'h7, 32'h7, 32'h80, 1'b0, 1'b1); tick();
        chk("mis_count_1", {28'b0, mispred_count}, 32'h1);
        chk("mis_flag_1", {31'b0, mispredict}, 32'h1);
        drive(1'b1, 3'b000, 32'h7, 32'h7, 32'h80, 1'b1, 1'b1); tick();
        chk("mis_flag_0", {31'b0, mispredict}, 32'h0);
        chk("mis_branch_count", {28'b0, branch_count}, 32'h2);

        // stall freezes, then flush during stall
        drive(1'b1, 3'b000, 32'h3, 32'h3, 32'hC0, 1'b1, 1'b1); tick();
        lookup_pc = 32'hC0;
        stall = 1'b1;
        drive(1'b1, 3'b000, 32'h1, 32'h2, 32'hC0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_res_valid", {31'b0, res_valid}, 32'h1);
            chk("stall_br_en", {31'b0, br_en}, 32'h1);
            chk("stall_mispredict", {31'b0, mispredict}, 32'h0);
            chk("stall_branch_count", {28'b0, branch_count}, 32'h3);
            chk("stall_mispred_count", {28'b0, mispred_count}, 32'h1);
            chk("stall_lookup", {31'b0, lookup_taken}, 32'h1);
        end
        flush = 1'b1;
        drive(1'b1, 3'b000, 32'h1, 32'h2, 32'hC0, 1'b0, 1'b0); tick();
        chk("flush_stall_res_valid", {31'b0, res_valid}, 32'h0);
        chk("flush_stall_count", {28'b0, branch_count}, 32'h3);
        chk("flush_stall_lookup", {31'b0, lookup_taken}, 32'h1);
        stall = 1'b0;
        drive(1'b1, 3'b000, 32'h1, 32'h2, 32'hC0, 1'b0, 1'b0); tick();
        chk("flush_res_valid", {31'b0, res_valid}, 32'h0);
        chk("flush_count", {28'b0, branch_count}, 32'h3);
        chk("flush_lookup", {31'b0, lookup_taken}, 32'h1);
        flush = 1'b0;
        idle(); tick();
        chk("idle_br_en", {31'b0, br_en}, 32'h0);
        chk("idle_mispredict", {31'b0, mispredict}, 32'h0);

        // same-cycle lookup and update at idx 3
        lookup_pc = 32'hC;
        drive(1'b1, 3'b000, 32'h1, 32'h1, 32'hC, 1'b0, 1'b1);
        #1;
        chk("bypass_old", {31'b0, lookup_taken}, 32'h0);
        tick();
        chk("bypass_new", {31'b0, lookup_taken}, 32'h1);
        idle(); tick();

        // counter wrap with CNT_W=4
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'b001, 32'h1, 32'h2, 32'h10, 1'b1, 1'b1);
            tick();
        end
        chk("wrap_branch_count", {28'b0, branch_count}, 32'h0);
        chk("wrap_mispred_count", {28'b0, mispred_count}, 32'h0);
        lookup_pc = 32'h10;
        #1;
        chk("wrap_lookup", {31'b0, lookup_taken}, 32'h1);

        // reset mid-stream beats a pending request
        rst = 1'b1;
        drive(1'b1, 3'b000, 32'h1, 32'h1, 32'h10, 1'b0, 1'b1);
        tick();
        chk("mid_rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("mid_rst_br_en", {31'b0, br_en}, 32'h0);
        chk("mid_rst_branch_count", {28'b0, branch_count}, 32'h0);
        chk("mid_rst_mispred_count", {28'b0, mispred_count}, 32'h0);
        chk("mid_rst_lookup", {31'b0, lookup_taken}, 32'h0);
        rst  = 1'b0;
        m_bc = '0;
        m_mc = '0;
        idle(); tick();
        tick();

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
